// File: rtl/para_reg_pkg.sv
// Shared definitions for the parallel-adder stimulus/response checker:
// FSM state encoding, LFSR polynomial and counter widths.
package para_reg_pkg;

    localparam int W_DEFAULT = 16;
    localparam int ERR_CNT_W = 16;

    // Galois feedback mask applied when the bit shifted out is 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = {1'b0, cur[31:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // A zero seed would lock the LFSR at zero, so it is replaced by 1.
    function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] seed);
        logic [31:0] res;
        if (seed == 32'h0000_0000) begin
            res = 32'h0000_0001;
        end else begin
            res = seed;
        end
        return res;
    endfunction

endpackage

// File: rtl/para_reg_checker_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enable.
// Load takes priority over enable; a zero seed loads 1.
module lfsr32
    import para_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        en_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Next-state selection: load, step or hold.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = lfsr_seed_fix(seed_i);
        end else if (en_i) begin
            state_d = lfsr_next(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // State register; reset value is the non-zero default seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 32'h0000_0001;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/para_reg_checker.sv
// Stimulus/response engine for a registered parallel adder. Drives seeded
// pseudo-random {c_in, a, b} vectors, delays the expected result to match
// the adder latency, counts mismatches and captures the first failing vector.
//
// The operand register acts as the push point of the delay line; LATENCY
// further stages behind it line the expected value up with the adder result,
// so a vector driven after edge k is compared in the cycle after edge k+LATENCY.
module para_reg_checker
    import para_reg_pkg::*;
#(
    parameter int W         = W_DEFAULT,
    parameter int LATENCY   = 1,
    parameter int N_VECTORS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          seed,
    output logic [W-1:0]         a,
    output logic [W-1:0]         b,
    output logic                 c_in,
    input  logic [W-1:0]         sum,
    input  logic                 c_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [W-1:0]         fail_a,
    output logic [W-1:0]         fail_b,
    output logic                 fail_c_in
);

    localparam logic [15:0]          VEC_LAST   = 16'(N_VECTORS - 1);
    // DRAIN covers the LATENCY pipeline cycles plus the final compare update.
    localparam logic [2:0]           DRAIN_LAST = 3'(LATENCY);
    localparam logic [ERR_CNT_W-1:0] ERR_ZERO   = {ERR_CNT_W{1'b0}};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE    = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // FSM and counters
    state_e      state_q, state_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;
    logic        accept_s;
    logic        run_s;
    logic [31:0] lfsr_s;

    // Operand register (delay-line entry point)
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         c_in_q, c_in_d;
    logic [W:0]   exp_q, exp_d;
    logic         vld_q, vld_d;

    // Delay line
    logic         pipe_vld_q [LATENCY];
    logic [W:0]   pipe_exp_q [LATENCY];
    logic [W-1:0] pipe_a_q   [LATENCY];
    logic [W-1:0] pipe_b_q   [LATENCY];
    logic         pipe_c_q   [LATENCY];

    // Result tracking
    logic                 mismatch_s;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [W-1:0]         fail_a_q, fail_a_d;
    logic [W-1:0]         fail_b_q, fail_b_d;
    logic                 fail_c_q, fail_c_d;
    logic                 first_q, first_d;
    logic                 busy_q, done_q, pass_q;

    assign accept_s = start && ((state_q == IDLE) || (state_q == DONE));
    assign run_s    = (state_q == RUN);

    lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept_s),
        .seed_i  (seed),
        .en_i    (run_s),
        .state_o (lfsr_s)
    );

    // FSM next-state and run/drain counters.
    always_comb begin
        state_d     = state_q;
        vec_cnt_d   = vec_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    vec_cnt_d   = 16'd0;
                    drain_cnt_d = 3'd0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                vec_cnt_d = vec_cnt_q + 16'd1;
                if (vec_cnt_q == VEC_LAST) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand generation: fresh vector from the LFSR in RUN, hold otherwise.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_in_d = c_in_q;
        exp_d  = exp_q;
        vld_d  = 1'b0;
        if (run_s) begin
            a_d    = lfsr_s[W-1:0];
            b_d    = lfsr_s[31:32-W];
            c_in_d = lfsr_s[0] ^ lfsr_s[31];
            exp_d  = {1'b0, a_d} + {1'b0, b_d} + {{W{1'b0}}, c_in_d};
            vld_d  = 1'b1;
        end else begin
            vld_d = 1'b0;
        end
    end

    assign mismatch_s = pipe_vld_q[LATENCY-1] &&
                        ({c_out, sum} != pipe_exp_q[LATENCY-1]);

    // Error counter and first-failure capture; a new run clears both.
    always_comb begin
        err_d    = err_q;
        fail_a_d = fail_a_q;
        fail_b_d = fail_b_q;
        fail_c_d = fail_c_q;
        first_d  = first_q;
        if (accept_s) begin
            err_d    = ERR_ZERO;
            fail_a_d = {W{1'b0}};
            fail_b_d = {W{1'b0}};
            fail_c_d = 1'b0;
            first_d  = 1'b0;
        end else if (mismatch_s) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_ONE;
            end else begin
                err_d = err_q;
            end
            if (!first_q) begin
                fail_a_d = pipe_a_q[LATENCY-1];
                fail_b_d = pipe_b_q[LATENCY-1];
                fail_c_d = pipe_c_q[LATENCY-1];
                first_d  = 1'b1;
            end else begin
                first_d = first_q;
            end
        end else begin
            err_d = err_q;
        end
    end

    // FSM, counters, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_cnt_q   <= 16'd0;
            drain_cnt_q <= 3'd0;
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            c_in_q      <= 1'b0;
            exp_q       <= {(W+1){1'b0}};
            vld_q       <= 1'b0;
            err_q       <= ERR_ZERO;
            fail_a_q    <= {W{1'b0}};
            fail_b_q    <= {W{1'b0}};
            fail_c_q    <= 1'b0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_cnt_q   <= vec_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_in_q      <= c_in_d;
            exp_q       <= exp_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
            fail_c_q    <= fail_c_d;
            first_q     <= first_d;
            busy_q      <= (state_d == RUN) || (state_d == DRAIN);
            done_q      <= (state_d == DONE);
            pass_q      <= (state_d == DONE) && (err_d == ERR_ZERO);
        end
    end

    // Delay line carrying valid, expected result and operands to the compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_exp_q[i] <= {(W+1){1'b0}};
                pipe_a_q[i]   <= {W{1'b0}};
                pipe_b_q[i]   <= {W{1'b0}};
                pipe_c_q[i]   <= 1'b0;
            end
        end else begin
            pipe_vld_q[0] <= vld_q;
            pipe_exp_q[0] <= exp_q;
            pipe_a_q[0]   <= a_q;
            pipe_b_q[0]   <= b_q;
            pipe_c_q[0]   <= c_in_q;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_exp_q[i] <= pipe_exp_q[i-1];
                pipe_a_q[i]   <= pipe_a_q[i-1];
                pipe_b_q[i]   <= pipe_b_q[i-1];
                pipe_c_q[i]   <= pipe_c_q[i-1];
            end
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign c_in      = c_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_c_in = fail_c_q;

endmodule

// File: tb/tb_para_reg_checker.sv
// Directed bench for para_reg_checker: two instances (LATENCY 1 and 3) each
// driving a bench-side adder model; an expected-vector queue is filled when
// a run is started and drained as the DUT drives each vector.
module tb_para_reg_checker;

    localparam int TW = 16;
    localparam int TN = 8;

    typedef struct packed {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          ci;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_tb = 1'b0;
    logic          sel3 = 1'b0;
    logic          fault1 = 1'b0;
    logic          lat1_mode = 1'b0;
    logic [31:0]   seed_tb = 32'd0;

    logic          start1, start3;
    logic [TW-1:0] a1, b1, sum1, fa1, fb1, a3, b3, sum3, fa3, fb3;
    logic          ci1, co1, busy1, done1, pass1, fc1;
    logic          ci3, co3, busy3, done3, pass3, fc3;
    logic [15:0]   err1, err3;

    logic [TW:0]   r1, s1, s2, s3;

    logic [TW-1:0] m_a, m_b, m_fa, m_fb;
    logic          m_ci, m_busy, m_done, m_pass, m_fc;
    logic [15:0]   m_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    assign start1 = start_tb & ~sel3;
    assign start3 = start_tb & sel3;

    para_reg_checker #(.W(TW), .LATENCY(1), .N_VECTORS(TN)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .seed(seed_tb),
        .a(a1), .b(b1), .c_in(ci1), .sum(sum1), .c_out(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_a(fa1), .fail_b(fb1), .fail_c_in(fc1)
    );

    para_reg_checker #(.W(TW), .LATENCY(3), .N_VECTORS(TN)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .seed(seed_tb),
        .a(a3), .b(b3), .c_in(ci3), .sum(sum3), .c_out(co3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_a(fa3), .fail_b(fb3), .fail_c_in(fc3)
    );

    // 1-stage adder for dut1, with optional inversion of sum[0]
    always_ff @(posedge clk) begin
        if (rst) r1 <= '0;
        else     r1 <= ({1'b0, a1} + {1'b0, b1} + {16'd0, ci1}) ^ {16'd0, fault1};
    end
    assign {co1, sum1} = r1;

    // 3-stage adder for dut3; lat1_mode taps the first stage instead
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0; s2 <= '0; s3 <= '0;
        end else begin
            s1 <= {1'b0, a3} + {1'b0, b3} + {16'd0, ci3};
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign {co3, sum3} = lat1_mode ? s1 : s3;

    assign m_a    = sel3 ? a3    : a1;
    assign m_b    = sel3 ? b3    : b1;
    assign m_ci   = sel3 ? ci3   : ci1;
    assign m_busy = sel3 ? busy3 : busy1;
    assign m_done = sel3 ? done3 : done1;
    assign m_pass = sel3 ? pass3 : pass1;
    assign m_err  = sel3 ? err3  : err1;
    assign m_fa   = sel3 ? fa3   : fa1;
    assign m_fb   = sel3 ? fb3   : fb1;
    assign m_fc   = sel3 ? fc3   : fc1;

    function automatic logic [31:0] step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0] == 1'b1) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // exp_err < 0 means "any non-zero count"; poke_k > 0 pulses start
    // with another seed while vector poke_k is on the bus.
    task automatic do_run(input logic [31:0] sd, input bit use3, input int n_lat,
                          input int exp_err, input int poke_k, input bit chk_fail);
        logic [31:0] s;
        vec_t        v;
        vec_t        first_v;
        int          e;
        sel3 = use3;
        s = (sd == 32'd0) ? 32'd1 : sd;
        for (int i = 0; i < TN; i++) begin
            v.a  = s[15:0];
            v.b  = s[31:16];
            v.ci = s[0] ^ s[31];
            exp_q.push_back(v);
            s = step(s);
        end
        first_v = exp_q[0];
        @(negedge clk);
        seed_tb  = sd;
        start_tb = 1'b1;
        @(posedge clk);
        #1;
        start_tb = 1'b0;
        for (int k = 1; k <= TN; k++) begin
            if (poke_k > 0 && k == poke_k + 1) begin
                @(negedge clk);
                seed_tb  = 32'hDEAD_BEEF;
                start_tb = 1'b1;
            end
            @(posedge clk);
            #1;
            start_tb = 1'b0;
            v = exp_q.pop_front();
            check($sformatf("vec%0d_a", k), {16'd0, m_a}, {16'd0, v.a});
            check($sformatf("vec%0d_b", k), {16'd0, m_b}, {16'd0, v.b});
            check($sformatf("vec%0d_cin", k), {31'd0, m_ci}, {31'd0, v.ci});
            if (k == 1) begin
                check("busy_run", {31'd0, m_busy}, 32'd1);
                check("done_clr", {31'd0, m_done}, 32'd0);
                check("err_clr", {16'd0, m_err}, 32'd0);
            end
        end
        e = TN;
        while (m_done !== 1'b1 && e < TN + 40) begin
            @(posedge clk);
            #1;
            e++;
        end
        check("done_edge", e, TN + n_lat + 1);
        check("busy_done", {31'd0, m_busy}, 32'd0);
        check("pass", {31'd0, m_pass}, (exp_err == 0) ? 32'd1 : 32'd0);
        if (exp_err < 0) check("err_nonzero", {31'd0, (m_err != 16'd0)}, 32'd1);
        else             check("err_count", {16'd0, m_err}, exp_err);
        if (chk_fail) begin
            check("fail_a", {16'd0, m_fa}, {16'd0, first_v.a});
            check("fail_b", {16'd0, m_fb}, {16'd0, first_v.b});
            check("fail_c_in", {31'd0, m_fc}, {31'd0, first_v.ci});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_done", {31'd0, done1}, 32'd0);
        check("rst_pass", {31'd0, pass1}, 32'd0);
        check("rst_err", {16'd0, err1}, 32'd0);
        check("rst_a", {16'd0, a1}, 32'd0);
        check("rst_fail_a", {16'd0, fa1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean run, stuck-bit fault, zero seed, another seed
        do_run(32'd1, 1'b0, 1, 0, 0, 1'b0);
        fault1 = 1'b1;
        do_run(32'd1, 1'b0, 1, 8, 0, 1'b1);
        fault1 = 1'b0;
        do_run(32'd0, 1'b0, 1, 0, 0, 1'b0);
        do_run(32'h1234_5678, 1'b0, 1, 0, 0, 1'b0);

        // Latency alignment on the 3-deep checker
        do_run(32'd1, 1'b1, 3, 0, 0, 1'b0);
        lat1_mode = 1'b1;
        do_run(32'd1, 1'b1, 3, -1, 0, 1'b0);
        lat1_mode = 1'b0;

        // Reset during vector 4 of a faulty run
        sel3   = 1'b0;
        fault1 = 1'b1;
        @(negedge clk);
        seed_tb  = 32'd1;
        start_tb = 1'b1;
        @(posedge clk);
        #1;
        start_tb = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_err", {16'd0, err1}, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_busy", {31'd0, busy1}, 32'd0);
        check("mrst_done", {31'd0, done1}, 32'd0);
        check("mrst_err", {16'd0, err1}, 32'd0);
        check("mrst_a", {16'd0, a1}, 32'd0);
        check("mrst_b", {16'd0, b1}, 32'd0);
        check("mrst_cin", {31'd0, ci1}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        fault1 = 1'b0;
        do_run(32'd1, 1'b0, 1, 0, 0, 1'b0);

        // Start pulse while busy is ignored
        do_run(32'd1, 1'b0, 1, 0, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
